ovl_fire_collector: RTL

Collects the per-cycle `fire` outputs of up to `NUM_CHK` OVL checkers (e.g. `ovl_never` instances) and turns them into a host-readable record. It sits directly downstream of the checker bank in the verification wrapper. It keeps:
- a saturating failure count per checker;
- a capture of the first failure;
- a small timestamped event FIFO drained through a valid/ready port.

---
 rtl/ovl_collect_pkg.sv | 25 ++
 rtl/ovl_evt_fifo.sv | 60 ++++++
 rtl/ovl_fire_collector.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ovl_collect_pkg.sv
// ---------------------------------------------------------------------------
// ovl_collect_pkg : shared types for the OVL fire collector
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ovl_collect_pkg;

   localparam int OVL_NUM_CHK = 8;
   localparam int OVL_TS_W    = 16;
   localparam int OVL_EVT_W   = OVL_NUM_CHK + OVL_TS_W;

   typedef struct packed {
      logic [OVL_NUM_CHK-1:0] mask;
      logic [OVL_TS_W-1:0]    ts;
   } ovl_evt_t;

   typedef enum logic [0:0] {
      S_IDLE     = 1'b0,
      S_CAPTURED = 1'b1
   } ovl_state_t;

endpackage

`default_nettype wire

// File: rtl/ovl_evt_fifo.sv
// ---------------------------------------------------------------------------
// ovl_evt_fifo : synchronous event FIFO, wrap-bit pointers, push accepted
//                when full if a pop happens in the same cycle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ovl_evt_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             valid,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             empty;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: the head is masked while the FIFO is empty.
   always_ff @(posedge clock) begin
      if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   assign valid = ~empty;
   assign rdata = valid ? mem[rd_ptr[AW-1:0]] : '0;

endmodule

`default_nettype wire

// File: rtl/ovl_fire_collector.sv
// ---------------------------------------------------------------------------
// ovl_fire_collector : per-checker fail counters, first-failure capture and
//                      timestamped event FIFO for a bank of OVL checkers
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ovl_fire_collector
   import ovl_collect_pkg::*;
#(
   parameter int NUM_CHK = OVL_NUM_CHK,
   parameter int CNT_W   = 8,
   parameter int TS_W    = OVL_TS_W,
   parameter int DEPTH   = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       enable,
   input  logic                       clear,
   input  logic [NUM_CHK-1:0]         fire,
   output logic                       evt_valid,
   input  logic                       evt_ready,
   output logic [NUM_CHK-1:0]         evt_mask,
   output logic [TS_W-1:0]            evt_ts,
   input  logic [$clog2(NUM_CHK)-1:0] rd_sel,
   output logic [CNT_W-1:0]           rd_cnt,
   output logic                       first_valid,
   output logic [NUM_CHK-1:0]         first_mask,
   output logic [TS_W-1:0]            first_ts,
   output logic                       overflow,
   output logic                       irq
);

   localparam int EVT_W = NUM_CHK + TS_W;

   logic [TS_W-1:0]  ts;
   logic [CNT_W-1:0] cnt [NUM_CHK];
   ovl_state_t       state;
   ovl_state_t       state_nxt;
   logic             capture;
   logic             evt_hit;
   logic             pop;
   logic             fifo_full;
   logic [EVT_W-1:0] head;

   // A clear in the same cycle discards the event everywhere.
   assign evt_hit = enable & (|fire) & ~clear;
   assign pop     = evt_valid & evt_ready;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) ts <= '0;
      else       ts <= ts + 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CHK; i++) cnt[i] <= '0;
      end else if (clear) begin
         for (int i = 0; i < NUM_CHK; i++) cnt[i] <= '0;
      end else if (evt_hit) begin
         for (int i = 0; i < NUM_CHK; i++) begin
            if (fire[i] && (cnt[i] != {CNT_W{1'b1}})) cnt[i] <= cnt[i] + 1'b1;
         end
      end
   end

   always_comb begin
      rd_cnt = '0;
      if (int'(rd_sel) < NUM_CHK) rd_cnt = cnt[rd_sel];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      case (state)
         S_IDLE: begin
            if (evt_hit) begin
               state_nxt = S_CAPTURED;
               capture   = 1'b1;
            end
         end
         S_CAPTURED: begin
            if (clear) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign first_valid = (state == S_CAPTURED);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         first_mask <= '0;
         first_ts   <= '0;
         overflow   <= 1'b0;
         irq        <= 1'b0;
      end else begin
         irq <= first_valid | overflow;
         if (clear) begin
            first_mask <= '0;
            first_ts   <= '0;
            overflow   <= 1'b0;
         end else begin
            if (capture) begin
               first_mask <= fire;
               first_ts   <= ts;
            end
            if (evt_hit && fifo_full && !pop) overflow <= 1'b1;
         end
      end
   end

   ovl_evt_fifo #(
      .WIDTH (EVT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .clear (clear),
      .push  (evt_hit),
      .pop   (pop),
      .wdata ({fire, ts}),
      .rdata (head),
      .valid (evt_valid),
      .full  (fifo_full)
   );

   assign evt_mask = head[EVT_W-1:TS_W];
   assign evt_ts   = head[TS_W-1:0];

endmodule

`default_nettype wire
